// File: rtl/alu_issue_queue.sv
// Flow-controlled issue stage in front of a combinational ALU: FIFO of {opcode,a,b} plus one-entry result register.
// Optional feature: define ALU_ISSUE_QUEUE_BYPASS_EN to let an empty queue feed the ALU straight from the input port.
module alu_issue_queue #(
   parameter int DEPTH = 4,
   parameter int W = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         io_in_valid,
   output logic                         io_in_ready,
   input  logic [W-1:0]                 io_in_a,
   input  logic [W-1:0]                 io_in_b,
   input  logic [1:0]                   io_in_opcode,
   output logic [W-1:0]                 io_alu_a,
   output logic [W-1:0]                 io_alu_b,
   output logic [1:0]                   io_alu_opcode,
   input  logic [W-1:0]                 io_alu_out,
   output logic                         io_res_valid,
   input  logic                         io_res_ready,
   output logic [W-1:0]                 io_res_bits,
   output logic [1:0]                   io_res_opcode,
   output logic [$clog2(DEPTH+1)-1:0]   io_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int EW = 2 + 2*W;

   logic [EW-1:0] mem_q [DEPTH];
   logic [EW-1:0] mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          res_valid_q, res_valid_d;
   logic [W-1:0]  res_bits_q, res_bits_d;
   logic [1:0]    res_opcode_q, res_opcode_d;

   logic          not_empty, slot_free, push, pop, bypass, fifo_push, capture;
   logic [EW-1:0] head;

   assign not_empty   = count_q != '0;
   assign io_in_ready = count_q != CW'(DEPTH);
   assign slot_free   = !res_valid_q || io_res_ready;
   assign push        = io_in_valid && io_in_ready;
   assign pop         = not_empty && slot_free;
   assign head        = mem_q[rd_ptr_q];

`ifdef ALU_ISSUE_QUEUE_BYPASS_EN
   assign bypass = !not_empty && slot_free && io_in_valid;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed op goes straight into the result register, so it must not also land in the FIFO.
   assign fifo_push = push && !bypass;
   assign capture   = pop || bypass;

   always_comb begin
      io_alu_opcode = '0;
      io_alu_a      = '0;
      io_alu_b      = '0;
      if (not_empty) begin
         {io_alu_opcode, io_alu_a, io_alu_b} = head;
      end else if (bypass) begin
         {io_alu_opcode, io_alu_a, io_alu_b} = {io_in_opcode, io_in_a, io_in_b};
      end
   end

   always_comb begin
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      res_valid_d  = res_valid_q;
      res_bits_d   = res_bits_q;
      res_opcode_d = res_opcode_q;
      if (fifo_push) begin
         mem_d[wr_ptr_q] = {io_in_opcode, io_in_a, io_in_b};
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(fifo_push) - CW'(pop);
      if (capture) begin
         res_valid_d  = 1'b1;
         res_bits_d   = io_alu_out;
         res_opcode_d = io_alu_opcode;
      end else if (io_res_ready) begin
         res_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         res_valid_q  <= 1'b0;
         res_bits_q   <= '0;
         res_opcode_q <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         res_valid_q  <= res_valid_d;
         res_bits_q   <= res_bits_d;
         res_opcode_q <= res_opcode_d;
      end
   end

   // Entry storage is never reset; occupancy is tracked solely by the pointers and count.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign io_res_valid  = res_valid_q;
   assign io_res_bits   = res_bits_q;
   assign io_res_opcode = res_opcode_q;
   assign io_count      = count_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: a bench-side ALU closes the loop, a negedge monitor checks results in order.
module tb_alu_issue_queue;
   localparam int DEPTH = 4;
   localparam int W = 4;
   localparam int CW = $clog2(DEPTH+1);
`ifdef ALU_ISSUE_QUEUE_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic          clk;
   logic          reset;
   logic          io_in_valid;
   logic          io_in_ready;
   logic [W-1:0]  io_in_a;
   logic [W-1:0]  io_in_b;
   logic [1:0]    io_in_opcode;
   logic [W-1:0]  io_alu_a;
   logic [W-1:0]  io_alu_b;
   logic [1:0]    io_alu_opcode;
   logic [W-1:0]  io_alu_out;
   logic          io_res_valid;
   logic          io_res_ready;
   logic [W-1:0]  io_res_bits;
   logic [1:0]    io_res_opcode;
   logic [CW-1:0] io_count;

   typedef struct packed {
      logic [W-1:0] bits;
      logic [1:0]   opcode;
   } exp_t;

   exp_t         exp_q[$];
   int           n_compared = 0;
   int           n_mismatched = 0;
   int           n_results = 0;
   logic         accepted = 1'b0;
   logic         stalled_prev = 1'b0;
   logic [W-1:0] stalled_bits = '0;
   logic [1:0]   stalled_op = '0;

   alu_issue_queue #(.DEPTH(DEPTH), .W(W)) dut (
      .clk(clk),
      .reset(reset),
      .io_in_valid(io_in_valid),
      .io_in_ready(io_in_ready),
      .io_in_a(io_in_a),
      .io_in_b(io_in_b),
      .io_in_opcode(io_in_opcode),
      .io_alu_a(io_alu_a),
      .io_alu_b(io_alu_b),
      .io_alu_opcode(io_alu_opcode),
      .io_alu_out(io_alu_out),
      .io_res_valid(io_res_valid),
      .io_res_ready(io_res_ready),
      .io_res_bits(io_res_bits),
      .io_res_opcode(io_res_opcode),
      .io_count(io_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
      case (op)
         2'd0:    return a + b;
         2'd1:    return a - b;
         2'd2:    return a;
         default: return b;
      endcase
   endfunction

   // Stand-in for the downstream combinational ALU.
   assign io_alu_out = alu_model(io_alu_a, io_alu_b, io_alu_opcode);

   task automatic check_value(input string name, input int actual, input int expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      if (exp_q.size() == 0) begin
         n_compared++;
         n_mismatched++;
         $display("[TB] FAIL unexpected_result: got bits %0d op %0d, expected no result", io_res_bits, io_res_opcode);
      end else begin
         e = exp_q.pop_front();
         check_value("res_bits", int'(io_res_bits), int'(e.bits));
         check_value("res_opcode", int'(io_res_opcode), int'(e.opcode));
      end
      n_results++;
   endtask

   always @(negedge clk) begin
      if (reset) begin
         stalled_prev <= 1'b0;
      end else begin
         if (stalled_prev && io_res_valid) begin
            check_value("stall_bits_stable", int'(io_res_bits), int'(stalled_bits));
            check_value("stall_op_stable", int'(io_res_opcode), int'(stalled_op));
         end
         if (io_res_valid && io_res_ready) begin
            checkOutput();
         end
         stalled_prev <= io_res_valid && !io_res_ready;
         stalled_bits <= io_res_bits;
         stalled_op   <= io_res_opcode;
      end
   end

   // One cycle of stimulus; an accepted op pushes its expected result into the scoreboard.
   task automatic applyStimulus(input logic valid, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [1:0] op, input logic rready, input logic [W-1:0] expected);
      exp_t e;
      @(posedge clk);
      #1;
      io_in_valid  = valid;
      io_in_a      = a;
      io_in_b      = b;
      io_in_opcode = op;
      io_res_ready = rready;
      @(negedge clk);
      accepted = valid && io_in_ready;
      if (accepted) begin
         e.bits   = expected;
         e.opcode = op;
         exp_q.push_back(e);
      end
      #1;
   endtask

   task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                          input logic rready, input logic [W-1:0] expected);
      int budget;
      budget = 0;
      accepted = 1'b0;
      while (!accepted && budget < 20) begin
         applyStimulus(1'b1, a, b, op, rready, expected);
         budget++;
      end
      if (!accepted) begin
         n_compared++;
         n_mismatched++;
         $display("[TB] FAIL send_timeout: got no accept in %0d cycles, expected accept", budget);
      end
   endtask

   task automatic idle_cycles(input int n, input logic rready);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, '0, '0, 2'd0, rready, '0);
      end
   endtask

   task automatic drain_results();
      int budget;
      budget = 0;
      while ((exp_q.size() != 0 || io_res_valid) && budget < 100) begin
         applyStimulus(1'b0, '0, '0, 2'd0, 1'b1, '0);
         budget++;
      end
      check_value("drain_complete", exp_q.size(), 0);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic [1:0]   rop;
      logic         rv, rr;
      int           n0;

      reset        = 1'b1;
      io_in_valid  = 1'b0;
      io_in_a      = '0;
      io_in_b      = '0;
      io_in_opcode = '0;
      io_res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      #1;

      $display("[TB] reset state");
      check_value("rst_res_valid", io_res_valid, 0);
      check_value("rst_count", int'(io_count), 0);
      check_value("rst_in_ready", io_in_ready, 1);
      check_value("rst_res_bits", int'(io_res_bits), 0);
      check_value("rst_res_opcode", int'(io_res_opcode), 0);
      check_value("rst_alu_a", int'(io_alu_a), 0);
      check_value("rst_alu_opcode", int'(io_alu_opcode), 0);

      $display("[TB] single op latency");
      applyStimulus(1'b1, 4'd9, 4'd8, 2'd0, 1'b1, 4'd1);
      check_value("lat_accept", accepted, 1);
      check_value("lat_valid_n", io_res_valid, 0);
      idle_cycles(1, 1'b1);
      check_value("lat_valid_n1", io_res_valid, int'(LAT == 1));
      idle_cycles(1, 1'b1);
      check_value("lat_valid_n2", io_res_valid, int'(LAT == 2));
      idle_cycles(2, 1'b1);

      $display("[TB] back-to-back ops");
      n0 = n_results;
      send_op(4'd3, 4'd5, 2'd1, 1'b1, 4'd14);
      send_op(4'd7, 4'd1, 2'd2, 1'b1, 4'd7);
      send_op(4'd2, 4'd12, 2'd3, 1'b1, 4'd12);
      send_op(4'd6, 4'd6, 2'd0, 1'b1, 4'd12);
      idle_cycles(LAT, 1'b1);
      check_value("b2b_result_count", n_results - n0, 4);
      idle_cycles(2, 1'b1);

      $display("[TB] output stall fills queue");
      send_op(4'd1, 4'd2, 2'd0, 1'b0, 4'd3);
      send_op(4'd9, 4'd3, 2'd1, 1'b0, 4'd6);
      send_op(4'd4, 4'd5, 2'd2, 1'b0, 4'd4);
      send_op(4'd4, 4'd5, 2'd3, 1'b0, 4'd5);
      send_op(4'd15, 4'd15, 2'd0, 1'b0, 4'd14);
      applyStimulus(1'b1, 4'd8, 4'd8, 2'd0, 1'b0, 4'd0);
      check_value("full_in_ready", io_in_ready, 0);
      check_value("full_count", int'(io_count), 4);
      check_value("full_res_valid", io_res_valid, 1);
      check_value("full_res_bits", int'(io_res_bits), 3);
      applyStimulus(1'b0, '0, '0, 2'd0, 1'b1, '0);
      check_value("full_ready_before_pop", io_in_ready, 0);
      applyStimulus(1'b0, '0, '0, 2'd0, 1'b1, '0);
      check_value("ready_after_pop", io_in_ready, 1);
      drain_results();

      $display("[TB] steady push and pop at count 2");
      send_op(4'd1, 4'd1, 2'd0, 1'b0, 4'd2);
      send_op(4'd8, 4'd3, 2'd1, 1'b0, 4'd5);
      send_op(4'd10, 4'd11, 2'd3, 1'b0, 4'd11);
      for (int i = 0; i < 10; i++) begin
         ra  = W'(i + 3);
         rb  = W'(2 * i + 1);
         rop = 2'(i);
         applyStimulus(1'b1, ra, rb, rop, 1'b1, alu_model(ra, rb, rop));
         check_value("steady_count", int'(io_count), 2);
      end
      drain_results();

      $display("[TB] reset mid-stream");
      for (int i = 0; i < 4; i++) begin
         send_op(W'(i + 1), W'(5), 2'd0, 1'b0, W'(i + 6));
      end
      idle_cycles(1, 1'b0);
      check_value("mid_count", int'(io_count), 3);
      check_value("mid_res_valid", io_res_valid, 1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      io_res_ready = 1'b1;
      @(negedge clk);
      #1;
      check_value("post_rst_count", int'(io_count), 0);
      check_value("post_rst_res_valid", io_res_valid, 0);
      check_value("post_rst_res_bits", int'(io_res_bits), 0);
      check_value("post_rst_res_opcode", int'(io_res_opcode), 0);
      check_value("post_rst_in_ready", io_in_ready, 1);
      n0 = n_results;
      idle_cycles(6, 1'b1);
      check_value("no_stale_results", n_results - n0, 0);

      $display("[TB] random valid/ready traffic");
      for (int i = 0; i < 2000; i++) begin
         rv  = 1'($urandom_range(0, 1));
         rr  = ($urandom_range(0, 3) != 0);
         ra  = W'($urandom_range(0, 15));
         rb  = W'($urandom_range(0, 15));
         rop = 2'($urandom_range(0, 3));
         applyStimulus(rv, ra, rb, rop, rr, alu_model(ra, rb, rop));
      end
      drain_results();

      $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
